// File: rtl/xor_pkg.sv
// Shared types and constants for the XOR parity generate/check path.
package xor_pkg;

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      PARITY
   } state_e;

   localparam int DATA_W_DEF = 8;
   localparam bit PAR_EVEN   = 1'b0;
   localparam bit PAR_ODD    = 1'b1;

endpackage

// File: rtl/xor_parity_acc.sv
// Single-bit running XOR accumulator with clear/load/enable controls.
module xor_parity_acc (
   input  logic clk,
   input  logic rst_n,
   input  logic clr_i,
   input  logic load_i,
   input  logic en_i,
   input  logic bit_i,
   output logic acc_o
);

   logic acc_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q <= 1'b0;
      end else if (clr_i) begin
         acc_q <= 1'b0;
      end else if (load_i) begin
         acc_q <= bit_i;
      end else if (en_i) begin
         acc_q <= acc_q ^ bit_i;
      end
   end

   assign acc_o = acc_q;

endmodule

// File: rtl/xor_parity_checker.sv
// Serial LSB-first frame receiver with parity check and valid/ready output.
// Define PARITY_ERR_CNT_EN to add the saturating err_cnt output.
//
// state  | meaning
// IDLE   | waiting for bit_vld & sof
// SHIFT  | collecting data bits 1..DATA_W-1
// PARITY | next valid bit is the parity bit; frame completes on it
module xor_parity_checker
   import xor_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter bit ODD    = PAR_EVEN
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              bit_in,
   input  logic              bit_vld,
   input  logic              sof,
   output logic [DATA_W-1:0] m_data,
   output logic              m_parity_err,
   output logic              m_valid,
   input  logic              m_ready,
   output logic              busy,
   output logic              overrun
`ifdef PARITY_ERR_CNT_EN
   ,
   output logic [15:0]       err_cnt
`endif
);

   localparam int CW = $clog2(DATA_W + 1);
   localparam logic [CW-1:0] LAST_IDX = CW'(DATA_W - 1);

   state_e            state_q;
   logic [CW-1:0]     count_q;
   logic [DATA_W-1:0] shift_q;
   logic [DATA_W-1:0] m_data_q;
   logic              m_err_q;
   logic              m_valid_q;
   logic              overrun_q;
   logic              acc;

   logic start, data_bit, frame_done, err, load_out;

   // sof with bit_vld always restarts, silently abandoning any partial frame
   assign start      = bit_vld & sof;
   assign data_bit   = bit_vld & ~sof & (state_q == SHIFT);
   assign frame_done = bit_vld & ~sof & (state_q == PARITY);
   assign err        = acc ^ bit_in ^ ODD;
   assign load_out   = frame_done & (~m_valid_q | m_ready);

   xor_parity_acc u_acc (
      .clk    (clk),
      .rst_n  (rst_n),
      .clr_i  (frame_done),
      .load_i (start),
      .en_i   (data_bit),
      .bit_i  (bit_in),
      .acc_o  (acc)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         count_q   <= '0;
         shift_q   <= '0;
         m_data_q  <= '0;
         m_err_q   <= 1'b0;
         m_valid_q <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         overrun_q <= 1'b0;
         if (start) begin
            shift_q <= DATA_W'(bit_in);
            count_q <= CW'(1);
            state_q <= (DATA_W == 1) ? PARITY : SHIFT;
         end else if (data_bit) begin
            shift_q <= shift_q | (DATA_W'(bit_in) << count_q);
            count_q <= count_q + 1'b1;
            if (count_q == LAST_IDX) state_q <= PARITY;
         end else if (frame_done) begin
            count_q <= '0;
            state_q <= IDLE;
         end

         if (load_out) begin
            m_data_q  <= shift_q;
            m_err_q   <= err;
            m_valid_q <= 1'b1;
         end else begin
            if (frame_done) overrun_q <= 1'b1;
            if (m_valid_q && m_ready) m_valid_q <= 1'b0;
         end
      end
   end

   assign m_data       = m_data_q;
   assign m_parity_err = m_err_q;
   assign m_valid      = m_valid_q;
   assign busy         = (state_q != IDLE);
   assign overrun      = overrun_q;

`ifdef PARITY_ERR_CNT_EN
   logic [15:0] err_cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_cnt_q <= '0;
      end else if (load_out && err && (err_cnt_q != 16'hFFFF)) begin
         err_cnt_q <= err_cnt_q + 16'd1;
      end
   end

   assign err_cnt = err_cnt_q;
`endif

endmodule
